// File: rtl/io_bus_timer_responder.sv
// I/O bus responder: 16-byte register window with wait-state acknowledge and a
// 32-bit down-counting interval timer whose timeout drives the bridge irq.
module io_bus_timer_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] ID_VALUE    = 16'h7A61
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] io_address,
  input  logic        io_bus_enable,
  input  logic [1:0]  io_byte_enable,
  input  logic        io_rw,
  input  logic [15:0] io_write_data,
  output logic [15:0] io_read_data,
  output logic        io_acknowledge,
  output logic        io_irq
);

  // state   | meaning
  // IDLE    | waiting for a request that hits the window
  // WAIT    | wait_cnt counts down the configured wait states
  // ACK     | one-cycle acknowledge, read data valid, write committed
  // TURN    | one dead cycle while the master drops bus_enable
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_TURN} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [2:0]  req_idx;
  logic        req_rw;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;

  logic        run, cont, irq_en, timeout;
  logic [31:0] period, period_nxt, count;
  logic [15:0] scratch, shadow, rd_mux;
  logic [2:0]  ctrl_w;
  logic        hit, wr_en, wr_ctrl, wr_status, wr_plo, wr_phi, wr_scr;
  logic        addr_unused;

  function automatic logic [15:0] merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                        input logic [1:0] be);
    return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
  endfunction

  assign hit         = (io_address[15:4] == BASE_ADDR[15:4]);
  assign addr_unused = io_address[0];

  assign wr_en     = (state == ST_ACK) && !req_rw;
  assign wr_ctrl   = wr_en && (req_idx == 3'd0);
  assign wr_status = wr_en && (req_idx == 3'd1);
  assign wr_plo    = wr_en && (req_idx == 3'd2);
  assign wr_phi    = wr_en && (req_idx == 3'd3);
  assign wr_scr    = wr_en && (req_idx == 3'd6);
  assign ctrl_w    = req_be[0] ? req_wdata[2:0] : {irq_en, cont, run};

  always_comb begin
    period_nxt = period;
    if (wr_plo) period_nxt[15:0]  = merge(period[15:0], req_wdata, req_be);
    if (wr_phi) period_nxt[31:16] = merge(period[31:16], req_wdata, req_be);
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (req_idx)
      3'd0: rd_mux = {13'b0, irq_en, cont, run};
      3'd1: rd_mux = {14'b0, run, timeout};
      3'd2: rd_mux = period[15:0];
      3'd3: rd_mux = period[31:16];
      3'd4: rd_mux = count[15:0];
      3'd5: rd_mux = shadow;
      3'd6: rd_mux = scratch;
      3'd7: rd_mux = ID_VALUE;
      default: rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt      = state;
    io_acknowledge = 1'b0;
    io_read_data   = 16'h0000;
    case (state)
      ST_IDLE: if (io_bus_enable && hit) state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: if (wait_cnt == 4'd0) state_nxt = ST_ACK;
      ST_ACK: begin
        io_acknowledge = 1'b1;
        if (req_rw) io_read_data = rd_mux;
        state_nxt = ST_TURN;
      end
      ST_TURN: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      req_idx   <= 3'd0;
      req_rw    <= 1'b0;
      req_be    <= 2'b00;
      req_wdata <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && io_bus_enable && hit) begin
        req_idx   <= io_address[3:1];
        req_rw    <= io_rw;
        req_be    <= io_byte_enable;
        req_wdata <= io_write_data;
        wait_cnt  <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
    end
  end

  // Later assignments win: timeout set beats W1C, CONTROL write beats one-shot auto-clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run     <= 1'b0;
      cont    <= 1'b0;
      irq_en  <= 1'b0;
      timeout <= 1'b0;
      period  <= 32'hFFFF_FFFF;
      count   <= 32'h0000_0000;
      scratch <= 16'h0000;
      shadow  <= 16'h0000;
      io_irq  <= 1'b0;
    end else begin
      period <= period_nxt;
      if (wr_status && req_be[0] && req_wdata[0]) timeout <= 1'b0;
      if (run) begin
        if (count != 32'd0) begin
          count <= count - 32'd1;
        end else begin
          count   <= period;
          timeout <= 1'b1;
          if (!cont) run <= 1'b0;
        end
      end
      if (!run && ((wr_ctrl && ctrl_w[0]) || wr_plo || wr_phi)) count <= period_nxt;
      if (wr_ctrl) begin
        run    <= ctrl_w[0];
        cont   <= ctrl_w[1];
        irq_en <= ctrl_w[2];
      end
      if (wr_scr) scratch <= merge(scratch, req_wdata, req_be);
      if (state == ST_ACK && req_rw && req_idx == 3'd4) shadow <= count[31:16];
      io_irq <= timeout & irq_en;
    end
  end

endmodule

// File: tb/tb_io_bus_timer_responder.sv
// Directed bench for io_bus_timer_responder: register vector table plus
// hand-timed sequences for ack latency, timer timeouts, W1C races and reset.
module tb_io_bus_timer_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] io_address;
  logic        io_bus_enable;
  logic [1:0]  io_byte_enable;
  logic        io_rw;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[$];

  io_bus_timer_responder #(
    .BASE_ADDR(16'h0100), .WAIT_STATES(1), .ID_VALUE(16'h7A61)
  ) dut (
    .clk(clk), .reset_n(reset_n), .io_address(io_address),
    .io_bus_enable(io_bus_enable), .io_byte_enable(io_byte_enable), .io_rw(io_rw),
    .io_write_data(io_write_data), .io_read_data(io_read_data),
    .io_acknowledge(io_acknowledge), .io_irq(io_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) step();
  endtask

  // Returns at 1ns after the edge that commits the transfer (state TURN follows).
  task automatic xfer(input logic rw, input logic [15:0] addr, input logic [1:0] be,
                      input logic [15:0] wd, output logic [15:0] rd, output int ea);
    io_rw = rw; io_address = addr; io_byte_enable = be; io_write_data = wd;
    io_bus_enable = 1'b1;
    ea = -1;
    rd = 16'h0000;
    for (int i = 0; i < 40 && ea < 0; i++) begin
      step();
      if (io_acknowledge) begin
        ea = cyc;
        rd = io_read_data;
      end
    end
    if (ea < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: no acknowledge for address %h within 40 cycles", addr);
    end
    step();
    io_bus_enable = 1'b0;
    check("ack_single_cycle", {15'b0, io_acknowledge}, 32'd0);
  endtask

  initial begin
    logic [15:0] rd;
    int ea, n0, e0, c0, miss_bad;

    vecs.push_back('{1'b0, 16'h010C, 2'b11, 16'hBEEF, 16'h0000});
    vecs.push_back('{1'b0, 16'h010C, 2'b01, 16'h1234, 16'h0000});
    vecs.push_back('{1'b1, 16'h010C, 2'b11, 16'h0000, 16'hBE34});
    vecs.push_back('{1'b0, 16'h010C, 2'b00, 16'hFFFF, 16'h0000});
    vecs.push_back('{1'b1, 16'h010D, 2'b11, 16'h0000, 16'hBE34});
    vecs.push_back('{1'b1, 16'h0100, 2'b11, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 16'h0104, 2'b11, 16'h0000, 16'hFFFF});
    vecs.push_back('{1'b1, 16'h0106, 2'b11, 16'h0000, 16'hFFFF});
    vecs.push_back('{1'b1, 16'h0108, 2'b11, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 16'h010E, 2'b11, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 16'h010E, 2'b11, 16'h0000, 16'h7A61});
    vecs.push_back('{1'b0, 16'h0100, 2'b11, 16'hFFF8, 16'h0000});
    vecs.push_back('{1'b1, 16'h0100, 2'b11, 16'h0000, 16'h0000});
    vecs.push_back('{1'b0, 16'h0104, 2'b10, 16'hAB00, 16'h0000});
    vecs.push_back('{1'b1, 16'h0104, 2'b11, 16'h0000, 16'hABFF});
    vecs.push_back('{1'b1, 16'h0108, 2'b11, 16'h0000, 16'hABFF});
    vecs.push_back('{1'b1, 16'h010A, 2'b11, 16'h0000, 16'hFFFF});
    vecs.push_back('{1'b0, 16'h0106, 2'b11, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 16'h0108, 2'b11, 16'h0000, 16'hABFF});
    vecs.push_back('{1'b1, 16'h010A, 2'b11, 16'h0000, 16'h0000});
    vecs.push_back('{1'b1, 16'h0102, 2'b11, 16'h0000, 16'h0000});

    reset_n = 1'b0;
    io_address = 16'h0000; io_bus_enable = 1'b0; io_byte_enable = 2'b00;
    io_rw = 1'b0; io_write_data = 16'h0000;
    repeat (3) step();
    check("reset_ack", {31'b0, io_acknowledge}, 32'd0);
    check("reset_rdata", {16'b0, io_read_data}, 32'd0);
    check("reset_irq", {31'b0, io_irq}, 32'd0);
    reset_n = 1'b1;
    step();

    // ID read: sampled on the next edge, one wait state, then acknowledge.
    n0 = cyc;
    xfer(1'b1, 16'h010E, 2'b11, 16'h0000, rd, ea);
    check("id_ack_latency", ea - n0, 32'd2);
    check("id_value", {16'b0, rd}, 32'h7A61);
    check("id_rdata_after_ack", {16'b0, io_read_data}, 32'd0);

    foreach (vecs[i]) begin
      xfer(vecs[i].rw, vecs[i].addr, vecs[i].be, vecs[i].wd, rd, ea);
      check($sformatf("vec%0d_rdata", i), {16'b0, rd}, {16'b0, vecs[i].exp});
    end

    step();
    io_rw = 1'b1; io_address = 16'h0200; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
    miss_bad = 0;
    repeat (20) begin
      step();
      if (io_acknowledge !== 1'b0 || io_read_data !== 16'h0000) miss_bad++;
    end
    io_bus_enable = 1'b0;
    check("miss_no_ack", miss_bad, 32'd0);

    // One-shot: PERIOD=5, timeout 6 cycles after the CONTROL write commits.
    xfer(1'b0, 16'h0104, 2'b11, 16'h0005, rd, ea);
    xfer(1'b0, 16'h0106, 2'b11, 16'h0000, rd, ea);
    xfer(1'b0, 16'h0100, 2'b11, 16'h0005, rd, ea);
    e0 = cyc;
    wait_to(e0 + 6);
    check("oneshot_irq_before", {31'b0, io_irq}, 32'd0);
    wait_to(e0 + 7);
    check("oneshot_irq_rise", {31'b0, io_irq}, 32'd1);
    xfer(1'b1, 16'h0102, 2'b11, 16'h0000, rd, ea);
    check("oneshot_status", {16'b0, rd}, 32'h0001);
    xfer(1'b1, 16'h0108, 2'b11, 16'h0000, rd, ea);
    check("oneshot_count_lo", {16'b0, rd}, 32'h0005);
    xfer(1'b1, 16'h010A, 2'b11, 16'h0000, rd, ea);
    check("oneshot_count_hi", {16'b0, rd}, 32'h0000);
    xfer(1'b0, 16'h0102, 2'b01, 16'h0001, rd, ea);
    e0 = cyc;
    check("w1c_irq_still_high", {31'b0, io_irq}, 32'd1);
    wait_to(e0 + 1);
    check("w1c_irq_drop", {31'b0, io_irq}, 32'd0);

    // Continuous, PERIOD=2: timeouts on edges c0+3k.
    xfer(1'b0, 16'h0104, 2'b11, 16'h0002, rd, ea);
    xfer(1'b0, 16'h0100, 2'b11, 16'h0007, rd, ea);
    c0 = cyc;
    wait_to(c0 + 3);
    check("cont_irq_before", {31'b0, io_irq}, 32'd0);
    wait_to(c0 + 4);
    check("cont_irq_rise", {31'b0, io_irq}, 32'd1);
    xfer(1'b1, 16'h0102, 2'b11, 16'h0000, rd, ea);
    check("cont_status", {16'b0, rd}, 32'h0003);

    step();
    while ((cyc - c0) % 3 != 0) step();
    xfer(1'b0, 16'h0102, 2'b01, 16'h0001, rd, ea);
    e0 = cyc;
    wait_to(e0 + 1);
    check("w1c_vs_timeout_set_wins", {31'b0, io_irq}, 32'd1);

    step();
    while ((cyc - c0) % 3 != 1) step();
    xfer(1'b0, 16'h0102, 2'b01, 16'h0001, rd, ea);
    e0 = cyc;
    wait_to(e0 + 1);
    check("cont_w1c_clear", {31'b0, io_irq}, 32'd0);
    wait_to(e0 + 3);
    check("cont_next_timeout", {31'b0, io_irq}, 32'd1);

    xfer(1'b0, 16'h0100, 2'b11, 16'h0000, rd, ea);
    xfer(1'b0, 16'h0102, 2'b01, 16'h0001, rd, ea);

    // Reset while a SCRATCH write sits in WAIT.
    step();
    io_rw = 1'b0; io_address = 16'h010C; io_byte_enable = 2'b11;
    io_write_data = 16'h55AA; io_bus_enable = 1'b1;
    step();
    reset_n = 1'b0;
    check("rst_mid_ack_wait", {31'b0, io_acknowledge}, 32'd0);
    step();
    io_bus_enable = 1'b0;
    check("rst_mid_ack", {31'b0, io_acknowledge}, 32'd0);
    check("rst_mid_rdata", {16'b0, io_read_data}, 32'd0);
    check("rst_mid_irq", {31'b0, io_irq}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    n0 = cyc;
    xfer(1'b1, 16'h010C, 2'b11, 16'h0000, rd, ea);
    check("rst_scratch_cleared", {16'b0, rd}, 32'd0);
    check("rst_next_latency", ea - n0, 32'd2);
    xfer(1'b0, 16'h010C, 2'b11, 16'h1357, rd, ea);
    xfer(1'b1, 16'h010C, 2'b11, 16'h0000, rd, ea);
    check("rst_scratch_rw", {16'b0, rd}, 32'h1357);
    xfer(1'b1, 16'h0104, 2'b11, 16'h0000, rd, ea);
    check("rst_period_lo", {16'b0, rd}, 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
